alu_sequencer: RTL and testbench

- Control-path stage directly upstream of the multi-stage ALU in the 10-bit processor.
- Latches a 10-bit instruction and steps a small FSM that drives the ALU's Ain, Gin, Gout and FN controls.
- Also drives register-file read/write addressing (read data feeds the ALU OP input via Q0) and the external-data mux select.
- Presents a start/done handshake to the instruction source.

---
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Control sequencer for the multi-stage ALU: latches an instruction and steps
// IDLE/EXEC1/ALU_G/ALU_W, driving ALU and register-file controls with a start/done handshake.
module alu_sequencer #(
   parameter logic [3:0] LOAD_CODE = 4'b0000,
   parameter logic [3:0] COPY_CODE = 4'b0001
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       exec,
   input  logic [9:0] instr,
   output logic [2:0] rd_addr,
   output logic [2:0] wr_addr,
   output logic       wr_en,
   output logic       extern_sel,
   output logic       Ain,
   output logic       Gin,
   output logic       Gout,
   output logic [3:0] FN,
   output logic       busy,
   output logic       done,
   output logic       dropped
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC1 = 2'd1,
      S_ALU_G = 2'd2,
      S_ALU_W = 2'd3
   } state_t;

   typedef struct packed {
      logic [2:0] rd_addr;
      logic [2:0] wr_addr;
      logic       wr_en;
      logic       extern_sel;
      logic       ain;
      logic       gin;
      logic       gout;
      logic [3:0] fn;
      logic       done;
      logic       busy;
   } ctl_t;

   state_t     r_state;
   logic [9:0] r_ir;
   ctl_t       r_ctl;
   logic       r_dropped;

   state_t     w_next_state;
   logic [9:0] w_next_ir;
   ctl_t       w_next_ctl;
   logic       w_accept;

   // Moore decode of a (state, IR) pair; applied to the next state so the
   // registered outputs line up with the state they describe.
   function automatic ctl_t decode(input state_t s, input logic [9:0] ir);
      ctl_t c;
      c = '0;
      case (s)
         S_EXEC1: begin
            c.busy = 1'b1;
            if (ir[9:6] == LOAD_CODE) begin
               c.extern_sel = 1'b1;
               c.wr_en      = 1'b1;
               c.wr_addr    = ir[5:3];
               c.done       = 1'b1;
            end else if (ir[9:6] == COPY_CODE) begin
               c.rd_addr    = ir[2:0];
               c.wr_en      = 1'b1;
               c.wr_addr    = ir[5:3];
               c.done       = 1'b1;
            end else begin
               c.rd_addr    = ir[5:3];
               c.ain        = 1'b1;
            end
         end
         S_ALU_G: begin
            c.busy    = 1'b1;
            c.rd_addr = ir[2:0];
            c.gin     = 1'b1;
            c.fn      = ir[9:6];
         end
         S_ALU_W: begin
            c.busy    = 1'b1;
            c.gout    = 1'b1;
            c.wr_en   = 1'b1;
            c.wr_addr = ir[5:3];
            c.done    = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      w_accept     = (r_state == S_IDLE) && exec;
      w_next_ir    = w_accept ? instr : r_ir;
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (exec) w_next_state = S_EXEC1;
         S_EXEC1: begin
            if ((r_ir[9:6] == LOAD_CODE) || (r_ir[9:6] == COPY_CODE))
               w_next_state = S_IDLE;
            else
               w_next_state = S_ALU_G;
         end
         S_ALU_G: w_next_state = S_ALU_W;
         S_ALU_W: w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
      w_next_ctl = decode(w_next_state, w_next_ir);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ir      <= '0;
         r_ctl     <= '0;
         r_dropped <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_ir    <= w_next_ir;
         r_ctl   <= w_next_ctl;
         if (w_accept)
            r_dropped <= 1'b0;
         else if (exec)
            r_dropped <= 1'b1;
      end
   end

   assign rd_addr    = r_ctl.rd_addr;
   assign wr_addr    = r_ctl.wr_addr;
   assign wr_en      = r_ctl.wr_en;
   assign extern_sel = r_ctl.extern_sel;
   assign Ain        = r_ctl.ain;
   assign Gin        = r_ctl.gin;
   assign Gout       = r_ctl.gout;
   assign FN         = r_ctl.fn;
   assign busy       = r_ctl.busy;
   assign done       = r_ctl.done;
   assign dropped    = r_dropped;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus queues hand-computed per-cycle
// control vectors; a negedge monitor pops one per busy cycle and checks idle cycles are all-zero.
module tb_alu_sequencer;

   logic       clk;
   logic       rst_n;
   logic       exec;
   logic [9:0] instr;
   logic [2:0] rd_addr;
   logic [2:0] wr_addr;
   logic       wr_en;
   logic       extern_sel;
   logic       Ain;
   logic       Gin;
   logic       Gout;
   logic [3:0] FN;
   logic       busy;
   logic       done;
   logic       dropped;

   int unsigned total = 0;
   int unsigned bad   = 0;
   bit          sim_end = 1'b0;
   logic [16:0] exp_q[$];

   alu_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .exec       (exec),
      .instr      (instr),
      .rd_addr    (rd_addr),
      .wr_addr    (wr_addr),
      .wr_en      (wr_en),
      .extern_sel (extern_sel),
      .Ain        (Ain),
      .Gin        (Gin),
      .Gout       (Gout),
      .FN         (FN),
      .busy       (busy),
      .done       (done),
      .dropped    (dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, expv);
      end
   endtask

   // {rd_addr, wr_addr, wr_en, extern_sel, Ain, Gin, Gout, FN, done, busy}
   function automatic logic [16:0] ev(input logic [2:0] rd, input logic [2:0] wr,
                                      input logic we, input logic ext, input logic ain,
                                      input logic gin, input logic gout,
                                      input logic [3:0] fn, input logic dn);
      return {rd, wr, we, ext, ain, gin, gout, fn, dn, 1'b1};
   endfunction

   function automatic logic [16:0] act_vec();
      return {rd_addr, wr_addr, wr_en, extern_sel, Ain, Gin, Gout, FN, done, busy};
   endfunction

   always @(negedge clk) begin
      if (!sim_end) begin
         if (busy === 1'b1) begin
            if (exp_q.size() == 0)
               chk("unexpected_busy_cycle", {15'd0, act_vec()}, 32'd0);
            else
               chk("busy_cycle_vector", {15'd0, act_vec()}, {15'd0, exp_q.pop_front()});
         end else begin
            chk("idle_all_zero", {15'd0, act_vec()}, 32'd0);
         end
      end
   end

   task automatic cyc(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [9:0] ins);
      instr = ins;
      exec  = 1'b1;
      cyc(1);
      exec  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      exec  = 1'b0;
      instr = '0;
      cyc(3);
      rst_n = 1'b1;
      cyc(5);
      chk("reset_dropped", {31'd0, dropped}, 32'd0);

      // LOAD R3 <= ext_data; instr changed after accept must not matter
      exp_q.push_back(ev(3'd0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
      issue(10'b0000_011_000);
      instr = 10'b1111_111_111;
      cyc(3);

      // COPY R2 <= R5
      exp_q.push_back(ev(3'd5, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
      issue(10'b0001_010_101);
      cyc(3);

      // ALU op, then back-to-back issue in the idle cycle after done
      exp_q.push_back(ev(3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
      exp_q.push_back(ev(3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0));
      exp_q.push_back(ev(3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1));
      issue(10'b0100_001_110);
      cyc(3);
      chk("b2b_idle_before_second", {31'd0, busy}, 32'd0);
      exp_q.push_back(ev(3'd7, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
      exp_q.push_back(ev(3'd7, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0));
      exp_q.push_back(ev(3'd0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1));
      issue(10'b0010_111_111);
      chk("b2b_accept_busy", {31'd0, busy}, 32'd1);
      cyc(4);

      // Collision: exec during ALU_G is ignored and sets dropped
      exp_q.push_back(ev(3'd4, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
      exp_q.push_back(ev(3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b0));
      exp_q.push_back(ev(3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1));
      issue(10'b0110_100_010);
      cyc(1);
      instr = 10'b0011_000_001;
      exec  = 1'b1;
      cyc(1);
      exec  = 1'b0;
      chk("collision_dropped_set", {31'd0, dropped}, 32'd1);
      cyc(1);
      chk("collision_dropped_hold", {31'd0, dropped}, 32'd1);
      chk("collision_not_accepted", {31'd0, busy}, 32'd0);
      cyc(1);
      exp_q.push_back(ev(3'd0, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
      issue(10'b0000_111_000);
      chk("dropped_cleared_on_accept", {31'd0, dropped}, 32'd0);
      cyc(3);

      // Mid-op reset during ALU_W
      exp_q.push_back(ev(3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
      exp_q.push_back(ev(3'd4, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b0));
      exp_q.push_back(ev(3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1));
      issue(10'b0101_011_100);
      cyc(2);
      chk("alu_w_wr_en_before_reset", {31'd0, wr_en}, 32'd1);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("reset_async_wr_en", {31'd0, wr_en}, 32'd0);
      chk("reset_async_gout", {31'd0, Gout}, 32'd0);
      chk("reset_async_done", {31'd0, done}, 32'd0);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
      chk("post_reset_busy", {31'd0, busy}, 32'd0);

      // Still functional after reset: COPY R0 <= R7
      exp_q.push_back(ev(3'd7, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
      issue(10'b0001_000_111);
      cyc(3);

      chk("scoreboard_drained", exp_q.size(), 32'd0);
      sim_end = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
